// File: rtl/cgra_pkg.sv
// Shared encodings for the CGRA compute tile.
// Command, operation and destination codes.
package cgra_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_CONFIG = 2'b01,
    CMD_DATA   = 2'b10,
    CMD_FLUSH  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MAC  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    DEST_SWITCH = 2'b00,
    DEST_NEXT   = 2'b01,
    DEST_PREV   = 2'b10,
    DEST_RSVD   = 2'b11
  } dest_e;

endpackage

// File: rtl/tile_result_fifo.sv
// Synchronous result FIFO for the compute tile.
// Push is refused when full, pop is refused when empty.
module tile_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are only observed behind the count.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/compute_tile_param.sv
// Parametrised CGRA compute tile: decode, weights, ALU,
// tagged result FIFO and destination demux.
module compute_tile_param
  import cgra_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int WGT_W      = 4,
  parameter int NUM_WGT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             switch_data_in,
  input  logic                          switch_valid_in,
  output logic                          switch_ready_out,
  output logic [DATA_W-1:0]             switch_data_out,
  output logic                          switch_valid_out,
  input  logic                          switch_ready_in,
  output logic [DATA_W-1:0]             next_pe_data_out,
  output logic                          next_pe_valid_out,
  input  logic                          next_pe_ready_in,
  output logic [DATA_W-1:0]             prev_pe_data_out,
  output logic                          prev_pe_valid_out,
  input  logic                          prev_pe_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW    = DATA_W - 2;
  localparam int IDX_W = $clog2(NUM_WGT);
  localparam int EW    = DATA_W + 2;

  logic [1:0]        cmd;
  logic [PW-1:0]     p;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [1:0]        head_tag;
  logic [DATA_W-1:0] head_data;

  logic [WGT_W-1:0]  wgt [NUM_WGT];
  op_e               op;
  dest_e             dest;
  logic [IDX_W-1:0]  wsel;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] mac;
  logic [DATA_W-1:0] result;

  assign cmd    = switch_data_in[DATA_W-1 -: 2];
  assign p      = switch_data_in[PW-1:0];
  assign accept = switch_valid_in && !full;
  assign push   = accept && (cmd == CMD_DATA);
  assign switch_ready_out = !full;

  assign x   = DATA_W'(p);
  assign w   = DATA_W'(wgt[wsel]);
  assign mac = acc + x * w;

  // ALU result for the DATA word currently on the input.
  always_comb begin
    result = x;
    unique case (op)
      OP_ADD:  result = x + w;
      OP_SUB:  result = x - w;
      OP_MAC:  result = mac;
      OP_PASS: result = x;
    endcase
  end

  // Command side effects: weights, config and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WGT; i++) wgt[i] <= '0;
      op   <= OP_ADD;
      dest <= DEST_SWITCH;
      wsel <= '0;
      acc  <= '0;
    end else if (accept) begin
      unique case (cmd_e'(cmd))
        CMD_LOAD:
          wgt[p[WGT_W+IDX_W-1:WGT_W]] <= p[WGT_W-1:0];
        CMD_CONFIG: begin
          op   <= op_e'(p[1:0]);
          dest <= (p[3:2] == DEST_RSVD) ? DEST_SWITCH
                                        : dest_e'(p[3:2]);
          wsel <= p[4+IDX_W-1:4];
        end
        CMD_DATA:
          if (op == OP_MAC) acc <= mac;
        CMD_FLUSH:
          acc <= '0;
      endcase
    end
  end

  tile_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({dest, result}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign head_tag  = head[EW-1 -: 2];
  assign head_data = head[DATA_W-1:0];

  // Route the head entry to exactly one port by its tag.
  always_comb begin
    switch_valid_out  = 1'b0;
    next_pe_valid_out = 1'b0;
    prev_pe_valid_out = 1'b0;
    switch_data_out   = '0;
    next_pe_data_out  = '0;
    prev_pe_data_out  = '0;
    if (!empty) begin
      unique case (dest_e'(head_tag))
        DEST_NEXT: begin
          next_pe_valid_out = 1'b1;
          next_pe_data_out  = head_data;
        end
        DEST_PREV: begin
          prev_pe_valid_out = 1'b1;
          prev_pe_data_out  = head_data;
        end
        default: begin
          switch_valid_out = 1'b1;
          switch_data_out  = head_data;
        end
      endcase
    end
    pop = (switch_valid_out  && switch_ready_in)
       || (next_pe_valid_out && next_pe_ready_in)
       || (prev_pe_valid_out && prev_pe_ready_in);
  end

endmodule

// File: tb/tb_compute_tile_param.sv
// Directed bench for compute_tile_param.
// Each task drives one scenario and checks inline.
module tb_compute_tile_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] switch_data_in;
  logic       switch_valid_in;
  logic       switch_ready_out;
  logic [7:0] switch_data_out;
  logic       switch_valid_out;
  logic       switch_ready_in;
  logic [7:0] next_pe_data_out;
  logic       next_pe_valid_out;
  logic       next_pe_ready_in;
  logic [7:0] prev_pe_data_out;
  logic       prev_pe_valid_out;
  logic       prev_pe_ready_in;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_CFG  = 2'b01;
  localparam logic [1:0] C_DATA = 2'b10;
  localparam logic [1:0] C_FLSH = 2'b11;

  always #5 clk = ~clk;

  compute_tile_param dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .switch_data_in    (switch_data_in),
    .switch_valid_in   (switch_valid_in),
    .switch_ready_out  (switch_ready_out),
    .switch_data_out   (switch_data_out),
    .switch_valid_out  (switch_valid_out),
    .switch_ready_in   (switch_ready_in),
    .next_pe_data_out  (next_pe_data_out),
    .next_pe_valid_out (next_pe_valid_out),
    .next_pe_ready_in  (next_pe_ready_in),
    .prev_pe_data_out  (prev_pe_data_out),
    .prev_pe_valid_out (prev_pe_valid_out),
    .prev_pe_ready_in  (prev_pe_ready_in),
    .fifo_count        (fifo_count)
  );

  task automatic send(input logic [1:0] c, input logic [5:0] pl);
    switch_data_in  = {c, pl};
    switch_valid_in = 1'b1;
    @(posedge clk); #1;
    switch_valid_in = 1'b0;
    switch_data_in  = '0;
  endtask

  task automatic pop_sw();
    switch_ready_in = 1'b1;
    @(posedge clk); #1;
    switch_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    switch_data_in = '0;
    switch_valid_in = 1'b0;
    switch_ready_in = 1'b0;
    next_pe_ready_in = 1'b0;
    prev_pe_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({switch_valid_out, next_pe_valid_out, prev_pe_valid_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids got %b want 000",
        {switch_valid_out, next_pe_valid_out, prev_pe_valid_out});
    end
    checks++;
    if ({switch_data_out, next_pe_data_out, prev_pe_data_out} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 000000",
        {switch_data_out, next_pe_data_out, prev_pe_data_out});
    end
    checks++;
    if (fifo_count !== 3'd0 || switch_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_count_ready got %0d/%b want 0/1",
        fifo_count, switch_ready_out);
    end
  endtask

  task automatic test_add();
    send(C_LOAD, 6'b01_0011);
    send(C_CFG,  6'b01_00_00);
    send(C_DATA, 6'd5);
    checks++;
    if (switch_valid_out !== 1'b1 || switch_data_out !== 8'd8) begin
      errors++;
      $display("FAIL add_result got %b/%0d want 1/8",
        switch_valid_out, switch_data_out);
    end
    checks++;
    if (next_pe_valid_out !== 1'b0 || prev_pe_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL add_other_ports got %b%b want 00",
        next_pe_valid_out, prev_pe_valid_out);
    end
    pop_sw();
    checks++;
    if (fifo_count !== 3'd0 || switch_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL add_pop got %0d/%b want 0/0",
        fifo_count, switch_valid_out);
    end
  endtask

  task automatic test_sub_mac();
    send(C_LOAD, 6'b00_0111);
    send(C_CFG,  6'b00_00_01);
    send(C_DATA, 6'd2);
    checks++;
    if (switch_data_out !== 8'hFB) begin
      errors++;
      $display("FAIL sub_wrap got %h want fb", switch_data_out);
    end
    pop_sw();
    send(C_LOAD, 6'b10_0010);
    send(C_CFG,  6'b10_00_10);
    send(C_DATA, 6'd3);
    send(C_DATA, 6'd4);
    checks++;
    if (fifo_count !== 3'd2 || switch_data_out !== 8'd6) begin
      errors++;
      $display("FAIL mac_first got %0d/%0d want 2/6",
        fifo_count, switch_data_out);
    end
    pop_sw();
    checks++;
    if (switch_data_out !== 8'd14) begin
      errors++;
      $display("FAIL mac_second got %0d want 14", switch_data_out);
    end
    pop_sw();
    send(C_FLSH, 6'd0);
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_no_push got %0d want 0", fifo_count);
    end
    send(C_DATA, 6'd1);
    checks++;
    if (switch_data_out !== 8'd2) begin
      errors++;
      $display("FAIL mac_after_flush got %0d want 2", switch_data_out);
    end
    pop_sw();
  endtask

  task automatic test_routing();
    send(C_CFG,  6'b00_01_11);
    send(C_DATA, 6'd1);
    send(C_CFG,  6'b00_10_11);
    send(C_DATA, 6'd2);
    checks++;
    if (next_pe_valid_out !== 1'b1 || next_pe_data_out !== 8'd1) begin
      errors++;
      $display("FAIL route_next got %b/%0d want 1/1",
        next_pe_valid_out, next_pe_data_out);
    end
    checks++;
    if (prev_pe_valid_out !== 1'b0 || prev_pe_data_out !== 8'd0
        || switch_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL route_block got %b/%0d/%b want 0/0/0",
        prev_pe_valid_out, prev_pe_data_out, switch_valid_out);
    end
    next_pe_ready_in = 1'b1;
    @(posedge clk); #1;
    next_pe_ready_in = 1'b0;
    checks++;
    if (prev_pe_valid_out !== 1'b1 || prev_pe_data_out !== 8'd2
        || next_pe_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL route_prev got %b/%0d/%b want 1/2/0",
        prev_pe_valid_out, prev_pe_data_out, next_pe_valid_out);
    end
    prev_pe_ready_in = 1'b1;
    @(posedge clk); #1;
    prev_pe_ready_in = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL route_drain got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_q [4];
    send(C_CFG, 6'b00_00_11);
    switch_valid_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      switch_data_in = {C_DATA, 6'(i)};
      @(posedge clk); #1;
    end
    checks++;
    if (fifo_count !== 3'd4 || switch_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full_state got %0d/%b want 4/0",
        fifo_count, switch_ready_out);
    end
    switch_data_in = {C_DATA, 6'd5};
    @(posedge clk); #1;
    checks++;
    if (fifo_count !== 3'd4 || switch_data_out !== 8'd1) begin
      errors++;
      $display("FAIL full_blocked got %0d/%0d want 4/1",
        fifo_count, switch_data_out);
    end
    switch_ready_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (fifo_count !== 3'd3 || switch_data_out !== 8'd2) begin
      errors++;
      $display("FAIL full_pop_no_push got %0d/%0d want 3/2",
        fifo_count, switch_data_out);
    end
    @(posedge clk); #1;
    checks++;
    if (fifo_count !== 3'd3 || switch_data_out !== 8'd3) begin
      errors++;
      $display("FAIL push_pop_same got %0d/%0d want 3/3",
        fifo_count, switch_data_out);
    end
    switch_ready_in = 1'b0;
    switch_data_in = {C_DATA, 6'd6};
    @(posedge clk); #1;
    switch_valid_in = 1'b0;
    switch_data_in = '0;
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL refill got %0d want 4", fifo_count);
    end
    exp_q = '{8'd3, 8'd4, 8'd5, 8'd6};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (switch_valid_out !== 1'b1 || switch_data_out !== exp_q[i]) begin
        errors++;
        $display("FAIL drain_%0d got %b/%0d want 1/%0d",
          i, switch_valid_out, switch_data_out, exp_q[i]);
      end
      pop_sw();
    end
    checks++;
    if (fifo_count !== 3'd0 || switch_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got %0d/%b want 0/1",
        fifo_count, switch_ready_out);
    end
  endtask

  task automatic test_mid_reset();
    send(C_LOAD, 6'b11_0101);
    send(C_CFG,  6'b11_00_10);
    send(C_DATA, 6'd1);
    send(C_DATA, 6'd1);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_fill got %0d want 2", fifo_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({switch_valid_out, next_pe_valid_out, prev_pe_valid_out} !== 3'b000
        || fifo_count !== 3'd0 || switch_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got %b/%0d/%b want 000/0/1",
        {switch_valid_out, next_pe_valid_out, prev_pe_valid_out},
        fifo_count, switch_ready_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(C_DATA, 6'd4);
    checks++;
    if (switch_data_out !== 8'd4) begin
      errors++;
      $display("FAIL post_reset_default got %0d want 4", switch_data_out);
    end
    pop_sw();
    send(C_LOAD, 6'b11_0001);
    send(C_CFG,  6'b11_00_10);
    send(C_DATA, 6'd3);
    checks++;
    if (switch_data_out !== 8'd3) begin
      errors++;
      $display("FAIL post_reset_acc got %0d want 3", switch_data_out);
    end
    pop_sw();
  endtask

  task automatic test_reserved_dest();
    send(C_CFG,  6'b00_11_11);
    send(C_DATA, 6'd9);
    checks++;
    if (switch_valid_out !== 1'b1 || switch_data_out !== 8'd9
        || next_pe_valid_out !== 1'b0 || prev_pe_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_dest got %b/%0d/%b/%b want 1/9/0/0",
        switch_valid_out, switch_data_out,
        next_pe_valid_out, prev_pe_valid_out);
    end
    pop_sw();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mac();
    test_routing();
    test_full();
    test_mid_reset();
    test_reserved_dest();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
